uart_tx_frame_gen: RTL and testbench



---
 rtl/uart_tx_pkg.sv | 22 ++
 rtl/uart_bit_timer.sv | 26 ++
 rtl/uart_tx_frame_gen.sv | 178 +++++++++++++++++
 tb/tb_uart_tx_frame_gen.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_pkg.sv
// Shared types and helpers for the parametrised UART transmitter.
package uart_tx_pkg;

  localparam int MAX_DATA_W = 9;

  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP, BREAK
  } tx_state_e;

  typedef enum logic {
    PAR_EVEN = 1'b0,
    PAR_ODD  = 1'b1
  } parity_e;

  // Even parity is the plain XOR of the payload; odd parity inverts it.
  // Narrower payloads are zero-extended, which leaves the XOR unchanged.
  function automatic logic calc_parity(input logic [MAX_DATA_W-1:0] data,
                                       input parity_e ptype);
    return (^data) ^ (ptype == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Loadable bit-period down-counter. o_tick is high while the count is 0,
// which marks the last clock of the current bit.
module uart_bit_timer #(
  parameter int PRESC_W = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               i_load,
  input  logic [PRESC_W-1:0] i_load_val,
  output logic               o_tick,
  output logic [PRESC_W-1:0] o_cnt
);

  logic [PRESC_W-1:0] r_cnt;

  // Reload at each bit start, otherwise count down and rest at zero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)           r_cnt <= '0;
    else if (i_load)        r_cnt <= i_load_val;
    else if (r_cnt != '0)   r_cnt <= r_cnt - PRESC_W'(1);
  end

  assign o_tick = (r_cnt == '0);
  assign o_cnt  = r_cnt;

endmodule

// File: rtl/uart_tx_frame_gen.sv
// Parametrised UART frame generator: start, DATA_W data bits LSB first,
// optional parity, one or two stop bits, internal bit timing.
// Optional macro UART_TX_BREAK_EN adds break_in and a BREAK state.
// busy_out is already low during the final clock of the last stop bit (the
// cycle done_out pulses), so a request in that cycle starts the next frame
// with no idle gap.
module uart_tx_frame_gen
  import uart_tx_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int PRESC_W = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               data_valid_in,
  input  logic [DATA_W-1:0]  data_in,
  input  logic               par_en_in,
  input  logic               par_type_in,
  input  logic               stop2_in,
  input  logic [PRESC_W-1:0] prescale_in,
`ifdef UART_TX_BREAK_EN
  input  logic               break_in,
`endif
  output logic               busy_out,
  output logic               done_out,
  output logic               tx_out
);

  tx_state_e          r_state;
  logic [DATA_W-1:0]  r_shift;
  logic [3:0]         r_bit_cnt;
  logic               r_stop_cnt;
  logic               r_par_en;
  logic               r_par_bit;
  logic               r_stop2;
  logic [PRESC_W-1:0] r_pm1;
  logic               r_busy;
  logic               r_done;
  logic               r_tx;

  logic               w_brk;
  logic               w_accept;
  logic               w_tick;
  logic [PRESC_W-1:0] w_cnt;
  logic [PRESC_W-1:0] w_pm1_in;
  logic               w_active;
  logic               w_last_bit;
  logic               w_final;
  logic               w_final_next;
  logic               w_load;

`ifdef UART_TX_BREAK_EN
  assign w_brk = break_in;
`else
  assign w_brk = 1'b0;
`endif

  // A prescale of 0 behaves as 1, so the reload value never underflows.
  assign w_pm1_in   = (prescale_in == '0) ? '0 : prescale_in - PRESC_W'(1);
  assign w_accept   = data_valid_in && !r_busy && !w_brk;
  assign w_active   = (r_state == START) || (r_state == DATA) ||
                      (r_state == PARITY) || (r_state == STOP);
  assign w_last_bit = (r_bit_cnt == 4'(DATA_W - 1));
  assign w_final    = (r_state == STOP) && (r_stop_cnt == r_stop2) && w_tick;

  // The next cycle is the last clock of the frame: either the last stop bit
  // counts down to zero, or it is entered with a one-clock bit period.
  assign w_final_next =
      ((r_state == STOP) && (r_stop_cnt == r_stop2) && (w_cnt == PRESC_W'(1))) ||
      ((r_pm1 == '0) && w_tick &&
       (((r_state == DATA) && w_last_bit && !r_par_en && !r_stop2) ||
        ((r_state == PARITY) && !r_stop2) ||
        ((r_state == STOP) && !r_stop_cnt && r_stop2)));

  assign w_load = w_accept || (w_active && w_tick && !w_final);

  uart_bit_timer #(.PRESC_W(PRESC_W)) u_timer (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_load     (w_load),
    .i_load_val (w_accept ? w_pm1_in : r_pm1),
    .o_tick     (w_tick),
    .o_cnt      (w_cnt)
  );

  // Frame FSM with serializer, bit/stop counters and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_shift    <= '0;
      r_bit_cnt  <= '0;
      r_stop_cnt <= 1'b0;
      r_par_en   <= 1'b0;
      r_par_bit  <= 1'b0;
      r_stop2    <= 1'b0;
      r_pm1      <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_tx       <= 1'b1;
    end else begin
      r_done <= w_final_next;
      if (w_final_next) r_busy <= 1'b0;
      if (w_accept) begin
        r_state    <= START;
        r_shift    <= data_in;
        r_par_en   <= par_en_in;
        r_par_bit  <= calc_parity(MAX_DATA_W'(data_in), parity_e'(par_type_in));
        r_stop2    <= stop2_in;
        r_pm1      <= w_pm1_in;
        r_bit_cnt  <= '0;
        r_stop_cnt <= 1'b0;
        r_busy     <= 1'b1;
        r_tx       <= 1'b0;
      end else begin
        case (r_state)
          IDLE: if (w_brk) begin
            r_state <= BREAK;
            r_busy  <= 1'b1;
            r_tx    <= 1'b0;
          end
          BREAK: if (!w_brk) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_tx    <= 1'b1;
          end
          START: if (w_tick) begin
            r_state   <= DATA;
            r_tx      <= r_shift[0];
            r_shift   <= r_shift >> 1;
            r_bit_cnt <= '0;
          end
          DATA: if (w_tick) begin
            if (w_last_bit) begin
              r_bit_cnt <= '0;
              if (r_par_en) begin
                r_state <= PARITY;
                r_tx    <= r_par_bit;
              end else begin
                r_state    <= STOP;
                r_stop_cnt <= 1'b0;
                r_tx       <= 1'b1;
              end
            end else begin
              r_tx      <= r_shift[0];
              r_shift   <= r_shift >> 1;
              r_bit_cnt <= r_bit_cnt + 4'd1;
            end
          end
          PARITY: if (w_tick) begin
            r_state    <= STOP;
            r_stop_cnt <= 1'b0;
            r_tx       <= 1'b1;
          end
          STOP: if (w_tick) begin
            if (w_final) begin
              r_stop_cnt <= 1'b0;
              if (w_brk) begin
                r_state <= BREAK;
                r_busy  <= 1'b1;
                r_tx    <= 1'b0;
              end else begin
                r_state <= IDLE;
              end
            end else begin
              r_stop_cnt <= 1'b1;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign busy_out = r_busy;
  assign done_out = r_done;
  assign tx_out   = r_tx;

endmodule

// File: tb/tb_uart_tx_frame_gen.sv
// Self-checking bench for uart_tx_frame_gen (DATA_W=8, PRESC_W=8).
// Reference: each frame is a list of line levels, each held max(P,1) clocks;
// busy is high on every frame clock but the last, done only on the last.
module tb_uart_tx_frame_gen;

  typedef struct {
    logic [7:0]  d;
    bit          pe;
    bit          pt;
    bit          s2;
    int unsigned ps;
  } cfg_t;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       data_valid_in = 1'b0;
  logic [7:0] data_in = '0;
  logic       par_en_in = 1'b0;
  logic       par_type_in = 1'b0;
  logic       stop2_in = 1'b0;
  logic [7:0] prescale_in = 8'd1;
  logic       busy_out, done_out, tx_out;
`ifdef UART_TX_BREAK_EN
  logic       break_in = 1'b0;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  uart_tx_frame_gen #(.DATA_W(8), .PRESC_W(8)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .data_valid_in (data_valid_in),
    .data_in       (data_in),
    .par_en_in     (par_en_in),
    .par_type_in   (par_type_in),
    .stop2_in      (stop2_in),
    .prescale_in   (prescale_in),
`ifdef UART_TX_BREAK_EN
    .break_in      (break_in),
`endif
    .busy_out      (busy_out),
    .done_out      (done_out),
    .tx_out        (tx_out)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t got=%0h exp=%0h", tag, $time, got, exp);
    end
  endtask

  function automatic int bit_p(input cfg_t c);
    return (c.ps == 0) ? 1 : int'(c.ps);
  endfunction

  function automatic int frame_len(input cfg_t c);
    return (1 + 8 + int'(c.pe) + 1 + int'(c.s2)) * bit_p(c);
  endfunction

  // Line level in frame clock k (1-based).
  function automatic logic exp_tx(input cfg_t c, input int k);
    int idx;
    idx = (k - 1) / bit_p(c);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return c.d[idx-1];
    if (c.pe && idx == 9) return (^c.d) ^ c.pt;
    return 1'b1;
  endfunction

  task automatic drive(input cfg_t c);
    data_valid_in = 1'b1;
    data_in       = c.d;
    par_en_in     = c.pe;
    par_type_in   = c.pt;
    stop2_in      = c.s2;
    prescale_in   = 8'(c.ps);
  endtask

  // Caller has driven c in the current cycle. Checks up to stop_at frame clocks.
  // chain: hold valid high all frame and present nc on the last clock.
  // noise: random requests of 0xFF and prescale changes mid-frame.
  task automatic run(input cfg_t c, input bit chain, input cfg_t nc,
                     input bit noise, input int stop_at);
    int len;
    len = frame_len(c);
    for (int k = 1; k <= len && k <= stop_at; k++) begin
      @(negedge clk);
      if (k == 1) begin
        data_valid_in = chain;
        data_in       = 8'($urandom);
        par_en_in     = 1'($urandom);
        par_type_in   = 1'($urandom);
        stop2_in      = 1'($urandom);
        prescale_in   = 8'($urandom);
      end else if (noise && k < len) begin
        data_valid_in = 1'($urandom);
        data_in       = 8'hFF;
        prescale_in   = 8'($urandom);
      end
      if (k == len) begin
        if (chain) drive(nc);
        else data_valid_in = 1'b0;
      end
      chk("tx",   32'(tx_out),   32'(exp_tx(c, k)));
      chk("busy", 32'(busy_out), 32'(k < len));
      chk("done", 32'(done_out), 32'(k == len));
    end
  endtask

  task automatic idle_chk();
    @(negedge clk);
    chk("idle_tx",   32'(tx_out),   32'd1);
    chk("idle_busy", 32'(busy_out), 32'd0);
    chk("idle_done", 32'(done_out), 32'd0);
  endtask

  function automatic cfg_t mk(input logic [7:0] d, input bit pe, input bit pt,
                              input bit s2, input int unsigned ps);
    cfg_t c;
    c.d = d; c.pe = pe; c.pt = pt; c.s2 = s2; c.ps = ps;
    return c;
  endfunction

  initial begin
    cfg_t c, n;
    n = mk(8'h00, 0, 0, 0, 1);

    repeat (2) @(negedge clk);
    chk("rst_tx",   32'(tx_out),   32'd1);
    chk("rst_busy", 32'(busy_out), 32'd0);
    chk("rst_done", 32'(done_out), 32'd0);
    reset_n = 1'b1;
    idle_chk();

    // 0xA5, even then odd parity, one stop, prescale 4
    c = mk(8'hA5, 1, 0, 0, 4); drive(c); run(c, 0, n, 0, 1000); idle_chk();
    c = mk(8'hA5, 1, 1, 0, 4); drive(c); run(c, 0, n, 0, 1000); idle_chk();
    // no parity, two stops, prescale 1
    c = mk(8'h00, 0, 0, 1, 1); drive(c); run(c, 0, n, 0, 1000); idle_chk();
    // prescale 0 behaves as 1
    c = mk(8'h81, 1, 0, 1, 0); drive(c); run(c, 0, n, 0, 1000); idle_chk();

    // back-to-back with valid held high
    c = mk(8'h3C, 1, 0, 0, 3); n = mk(8'hC3, 0, 1, 1, 2);
    drive(c); run(c, 1, n, 0, 1000);
    run(n, 0, c, 0, 1000); idle_chk();
    // back-to-back at prescale 1
    c = mk(8'h55, 0, 0, 0, 1); n = mk(8'hAA, 1, 1, 0, 1);
    drive(c); run(c, 1, n, 0, 1000);
    run(n, 0, c, 0, 1000); idle_chk();

    // requests and prescale changes mid-frame are ignored
    c = mk(8'h12, 1, 0, 1, 3); drive(c); run(c, 0, n, 1, 1000); idle_chk();

    // reset in the DATA state, then a fresh frame
    c = mk(8'hE7, 1, 0, 0, 4); drive(c); run(c, 0, n, 0, 14);
    reset_n = 1'b0;
    #1;
    chk("mrst_tx",   32'(tx_out),   32'd1);
    chk("mrst_busy", 32'(busy_out), 32'd0);
    chk("mrst_done", 32'(done_out), 32'd0);
    @(negedge clk);
    chk("mrst_done2", 32'(done_out), 32'd0);
    reset_n = 1'b1;
    c = mk(8'h5A, 1, 0, 0, 4); drive(c); run(c, 0, n, 0, 1000); idle_chk();

    // randomized frames, some chained, some with mid-frame noise
    c = mk(8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), $urandom_range(0, 5));
    drive(c);
    for (int i = 0; i < 30; i++) begin
      bit ch;
      ch = 1'($urandom);
      n = mk(8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), $urandom_range(0, 5));
      run(c, ch, n, ch ? 1'b0 : 1'($urandom), 1000);
      if (!ch) begin
        idle_chk();
        drive(n);
      end
      c = n;
    end
    run(c, 0, n, 0, 1000); idle_chk();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
